// File: rtl/retro_mem_port_if.sv
// CPU byte-bus signals between the retro CPU (master) and its memory-side responder (slave).
interface retro_mem_port_if #(
  parameter int ADDRESS_WIDTH = 16
);
  logic [ADDRESS_WIDTH-1:0] address;
  logic [7:0]               wdata;
  logic                     wren;
  logic [7:0]               rdata;
  logic                     hold;

  modport master (
    output address,
    output wdata,
    output wren,
    input  rdata,
    input  hold
  );

  modport slave (
    input  address,
    input  wdata,
    input  wren,
    output rdata,
    output hold
  );
endinterface

// File: rtl/retro_mem_port.sv
// Memory-side responder for the retro CPU byte bus: on-chip RAM plus a small
// I/O page (LED register, free-running timer with coherent high-byte snapshot),
// with configurable wait states signalled to the CPU through hold.
module retro_mem_port #(
  parameter int          ADDRESS_WIDTH  = 16,
  parameter int          RAM_ADDR_WIDTH = 12,
  parameter int          WAIT_STATES    = 0,
  parameter int unsigned IO_BASE        = 32'hFF00,
  parameter string       INIT_FILE      = ""
) (
  input  logic             clk,
  input  logic             res,
  retro_mem_port_if.slave  bus,
  output logic [7:0]       led
);

  localparam logic [ADDRESS_WIDTH-1:0] LP_IO_BASE = ADDRESS_WIDTH'(IO_BASE);
  localparam logic [3:0]               LP_WAITS   = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_ACCEPT,
    S_WAIT,
    S_DONE
  } state_t;

  state_t     r_state;
  logic [3:0] r_wait_cnt;
  logic       r_is_rd;
  logic [7:0] r_rd_buf;
  logic [7:0] r_rdata;
  logic [7:0] r_led;
  logic [7:0] r_snap;
  logic [15:0] r_timer;

  logic [7:0] r_ram [2**RAM_ADDR_WIDTH];

  logic                      w_is_io;
  logic [RAM_ADDR_WIDTH-1:0] w_ram_idx;
  logic [7:0]                w_io_off;
  logic [7:0]                w_rd_val;
  logic                      w_accept;

  // The address is stable while hold is high, so decoding the live bus in
  // ACCEPT is equivalent to decoding the captured address.
  assign w_is_io   = (bus.address >= LP_IO_BASE);
  assign w_ram_idx = bus.address[RAM_ADDR_WIDTH-1:0];
  assign w_io_off  = bus.address[7:0];
  assign w_accept  = (r_state == S_ACCEPT);

  assign bus.hold  = (r_state != S_DONE);
  assign bus.rdata = r_rdata;
  assign led       = r_led;

  // Read-data selection for the access being accepted.
  always_comb begin
    w_rd_val = '0;
    if (w_is_io) begin
      case (w_io_off)
        8'h00:   w_rd_val = r_led;
        8'h01:   w_rd_val = r_timer[7:0];
        8'h02:   w_rd_val = r_snap;
        default: w_rd_val = '0;
      endcase
    end else begin
      w_rd_val = r_ram[w_ram_idx];
    end
  end

  // RAM write port; commits only on an un-reset ACCEPT edge.
  always_ff @(posedge clk) begin
    if (!res && w_accept && bus.wren && !w_is_io) begin
      r_ram[w_ram_idx] <= bus.wdata;
    end
  end

  // Free-running 16-bit timer.
  always_ff @(posedge clk) begin
    if (res) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 16'd1;
    end
  end

  // Access FSM: ACCEPT performs the access, WAIT burns wait states, DONE releases hold.
  always_ff @(posedge clk) begin
    if (res) begin
      r_state    <= S_ACCEPT;
      r_wait_cnt <= '0;
      r_is_rd    <= 1'b0;
      r_rd_buf   <= '0;
      r_rdata    <= '0;
      r_led      <= '0;
      r_snap     <= '0;
    end else begin
      case (r_state)
        S_ACCEPT: begin
          r_is_rd  <= !bus.wren;
          r_rd_buf <= w_rd_val;
          if (!bus.wren) begin
            // Without wait states this edge is also the last hold cycle,
            // so the read result goes straight to rdata.
            if (WAIT_STATES == 0) begin
              r_rdata <= w_rd_val;
            end
            if (w_is_io && (w_io_off == 8'h01)) begin
              r_snap <= r_timer[15:8];
            end
          end else if (w_is_io && (w_io_off == 8'h00)) begin
            r_led <= bus.wdata;
          end
          if (WAIT_STATES > 0) begin
            r_state    <= S_WAIT;
            r_wait_cnt <= LP_WAITS;
          end else begin
            r_state <= S_DONE;
          end
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt - 4'd1;
          if (r_wait_cnt == 4'd1) begin
            r_state <= S_DONE;
            if (r_is_rd) begin
              r_rdata <= r_rd_buf;
            end
          end
        end
        S_DONE: begin
          r_state <= S_ACCEPT;
        end
        default: begin
          r_state <= S_ACCEPT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_retro_mem_port.sv
// Bench for retro_mem_port: two instances (0 and 3 wait states) driven by a
// CPU-like access task and checked against a behavioural memory/I-O model.
module tb_retro_mem_port;

  logic        clk = 1'b0;
  logic        res;
  logic [15:0] t_addr;
  logic [7:0]  t_wdata;
  logic        t_wren;
  logic [7:0]  led0;
  logic [7:0]  led3;

  always #5 clk = ~clk;

  retro_mem_port_if #(.ADDRESS_WIDTH(16)) bus0 ();
  retro_mem_port_if #(.ADDRESS_WIDTH(16)) bus3 ();

  assign bus0.address = t_addr;
  assign bus0.wdata   = t_wdata;
  assign bus0.wren    = t_wren;
  assign bus3.address = t_addr;
  assign bus3.wdata   = t_wdata;
  assign bus3.wren    = t_wren;

  retro_mem_port #(
    .ADDRESS_WIDTH (16),
    .RAM_ADDR_WIDTH(12),
    .WAIT_STATES   (0),
    .IO_BASE       (32'hFF00),
    .INIT_FILE     ("")
  ) u_dut0 (
    .clk (clk),
    .res (res),
    .bus (bus0),
    .led (led0)
  );

  retro_mem_port #(
    .ADDRESS_WIDTH (16),
    .RAM_ADDR_WIDTH(12),
    .WAIT_STATES   (3),
    .IO_BASE       (32'hFF00),
    .INIT_FILE     ("")
  ) u_dut3 (
    .clk (clk),
    .res (res),
    .bus (bus3),
    .led (led3)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0]  m_mem [int];
  logic [7:0]  m_led;
  logic [7:0]  m_snap;
  logic [7:0]  m_rdata;
  logic [15:0] m_timer;

  // Timer reference: counts cycles since reset was last sampled high.
  always @(posedge clk) m_timer <= res ? 16'h0000 : m_timer + 16'h0001;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic hold_of(input int w);
    return (w == 0) ? bus0.hold : bus3.hold;
  endfunction

  function automatic logic [7:0] rdata_of(input int w);
    return (w == 0) ? bus0.rdata : bus3.rdata;
  endfunction

  function automatic logic [7:0] led_of(input int w);
    return (w == 0) ? led0 : led3;
  endfunction

  task automatic model_reset();
    m_led   = 8'h00;
    m_snap  = 8'h00;
    m_rdata = 8'h00;
  endtask

  // Hold reset for n cycles, checking the reset-state outputs of both instances.
  task automatic do_reset(input int n);
    res = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("rst_hold0", bus0.hold, 1'b1);
      check("rst_hold3", bus3.hold, 1'b1);
      check("rst_rdata0", bus0.rdata, 8'h00);
      check("rst_led0", led0, 8'h00);
      check("rst_led3", led3, 8'h00);
    end
    res = 1'b0;
    model_reset();
  endtask

  // One CPU access, entered during an ACCEPT cycle; returns during the next ACCEPT.
  task automatic access(input int w, input logic [15:0] a, input logic we, input logic [7:0] d);
    int         cnt;
    int         exp_hold;
    logic [15:0] tsamp;
    logic [7:0]  off;
    exp_hold = (w == 0) ? 1 : 4;
    cnt      = 0;
    t_addr   = a;
    t_wren   = we;
    t_wdata  = d;
    tsamp    = m_timer;
    off      = a[7:0];
    if (we) begin
      if (a >= 16'hFF00) begin
        if (off == 8'h00) m_led = d;
      end else begin
        m_mem[int'(a[11:0])] = d;
      end
    end else begin
      if (a >= 16'hFF00) begin
        case (off)
          8'h00: m_rdata = m_led;
          8'h01: begin m_rdata = tsamp[7:0]; m_snap = tsamp[15:8]; end
          8'h02: m_rdata = m_snap;
          default: m_rdata = 8'h00;
        endcase
      end else begin
        m_rdata = m_mem[int'(a[11:0])];
      end
    end
    while (hold_of(w) === 1'b1 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("hold_cycles", cnt, exp_hold);
    check("rdata", rdata_of(w), m_rdata);
    check("led", led_of(w), m_led);
    @(posedge clk); #1;
  endtask

  task automatic random_access(input int w);
    int          r;
    logic [11:0] idx;
    logic [3:0]  hi;
    logic [7:0]  off;
    logic [15:0] a;
    logic        we;
    r = $urandom_range(0, 9);
    if (r < 6) begin
      idx = 12'(($urandom_range(0, 31) * 131) % 4096);
      hi  = 4'($urandom_range(0, 14));
      a   = {hi, idx};
      we  = !m_mem.exists(int'(idx)) || ($urandom_range(0, 2) == 0);
    end else begin
      case ($urandom_range(0, 3))
        0: off = 8'h00;
        1: off = 8'h01;
        2: off = 8'h02;
        default: off = 8'($urandom_range(0, 255));
      endcase
      a  = {8'hFF, off};
      we = ($urandom_range(0, 3) == 0);
    end
    access(w, a, we, 8'($urandom_range(0, 255)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int guard;
    res     = 1'b1;
    t_addr  = 16'h0000;
    t_wren  = 1'b0;
    t_wdata = 8'h00;
    @(posedge clk); #1;

    // ---------------- zero wait states ----------------
    do_reset(3);
    access(0, 16'h0010, 1'b1, 8'hA5);
    access(0, 16'h0010, 1'b0, 8'h00);
    check("ram_rd_a5", bus0.rdata, 8'hA5);
    access(0, 16'h1010, 1'b0, 8'h00);
    check("ram_alias", bus0.rdata, 8'hA5);
    access(0, 16'hFF00, 1'b1, 8'h3C);
    check("led_3c", led0, 8'h3C);
    access(0, 16'hFF00, 1'b0, 8'h00);
    check("io_led_rd", bus0.rdata, 8'h3C);
    access(0, 16'hFF05, 1'b0, 8'h00);
    check("io_unmapped", bus0.rdata, 8'h00);
    access(0, 16'hFF01, 1'b1, 8'h99);
    access(0, 16'hFF00, 1'b0, 8'h00);
    check("io_ro_write", bus0.rdata, 8'h3C);

    // Reset asserted during the ACCEPT cycle of a write must not commit it.
    access(0, 16'h0020, 1'b1, 8'h11);
    t_addr  = 16'h0020;
    t_wren  = 1'b1;
    t_wdata = 8'h77;
    res     = 1'b1;
    @(posedge clk); #1;
    check("midrst_hold", bus0.hold, 1'b1);
    res = 1'b0;
    model_reset();
    access(0, 16'h0020, 1'b0, 8'h00);
    check("midrst_abort", bus0.rdata, 8'h11);

    for (int i = 0; i < 300; i++) random_access(0);

    // ---------------- three wait states ----------------
    do_reset(2);
    m_mem.delete();
    access(3, 16'hFF00, 1'b0, 8'h00);
    access(3, 16'hFF00, 1'b0, 8'h00);

    // Accesses every 5 cycles put an ACCEPT at timer 0x00FF.
    guard = 0;
    while (m_timer != 16'h00FF && guard < 100) begin
      access(3, 16'hFF05, 1'b0, 8'h00);
      guard++;
    end
    check("timer_align", m_timer, 16'h00FF);
    access(3, 16'hFF01, 1'b0, 8'h00);
    check("timer_lo", bus3.rdata, 8'hFF);
    access(3, 16'hFF02, 1'b0, 8'h00);
    check("timer_hi", bus3.rdata, 8'h00);

    access(3, 16'h0300, 1'b1, 8'h5A);
    access(3, 16'h0300, 1'b0, 8'h00);
    check("ws_ram_rd", bus3.rdata, 8'h5A);
    for (int i = 0; i < 60; i++) random_access(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
